// File: rtl/aes_out_collector.sv
// Output collector for the pipelined AES-128 core: tracks issues, buffers ciphertexts, streams 32-bit words.
// Define AES_OUT_PARITY_EN to add per-byte parity on m_data (m_par) and a sticky storage parity error (par_err).
module aes_out_collector #(
    parameter int unsigned LATENCY = 21,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   issue_ready,
    input  logic [127:0]           core_out,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_data,
    output logic                   m_last,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   overflow
`ifdef AES_OUT_PARITY_EN
    ,
    output logic [3:0]             m_par,
    output logic                   par_err
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = PW + 1;
    localparam int unsigned IW = 7;
    localparam int unsigned CW = IW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [LATENCY-1:0] r_vdly;
    logic [IW-1:0]      r_inflight;
    logic [FW-1:0]      r_fill;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [1:0]         r_idx;
    logic [0:0]         r_state;
    logic               r_overflow;
    logic [127:0]       r_mem [DEPTH];

    logic               w_emerge;
    logic               w_hs;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [FW-1:0]      w_fill_nxt;
    logic [CW-1:0]      w_committed;
    logic [127:0]       w_head;
    logic [31:0]        w_word;

    generate
        if (LATENCY == 1) begin : g_dly1
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_vdly <= '0;
                else      r_vdly <= in_valid;
            end
        end else begin : g_dlyn
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_vdly <= '0;
                else      r_vdly <= {r_vdly[LATENCY-2:0], in_valid};
            end
        end
    endgenerate

    assign w_emerge = r_vdly[LATENCY-1];
    assign w_head   = r_mem[r_rd_ptr];
    assign m_valid  = (r_state == ST_SEND);
    assign w_hs     = m_valid & m_ready;
    assign w_pop    = w_hs & (r_idx == 2'd3);
    assign w_full   = (r_fill == FW'(DEPTH));
    // A full FIFO still accepts the emerging block when the head pops in the same cycle.
    assign w_push   = w_emerge & (~w_full | w_pop);
    assign w_drop   = w_emerge & w_full & ~w_pop;

    always_comb begin
        w_fill_nxt = r_fill;
        case ({w_push, w_pop})
            2'b10:   w_fill_nxt = r_fill + FW'(1);
            2'b01:   w_fill_nxt = r_fill - FW'(1);
            default: w_fill_nxt = r_fill;
        endcase
    end

    assign w_committed = CW'(r_inflight) + CW'(r_fill);
    assign issue_ready = (w_committed < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
            r_fill     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_idx      <= '0;
            r_state    <= ST_IDLE;
            r_overflow <= 1'b0;
        end else begin
            case ({in_valid, w_emerge})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: r_inflight <= r_inflight;
            endcase
            r_fill <= w_fill_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_hs)   r_idx    <= r_idx + 2'd1;
            r_state <= (w_fill_nxt != '0) ? ST_SEND : ST_IDLE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= core_out;
    end

    always_comb begin
        w_word = '0;
        if (m_valid) begin
            case (r_idx)
                2'd0: w_word = w_head[127:96];
                2'd1: w_word = w_head[95:64];
                2'd2: w_word = w_head[63:32];
                2'd3: w_word = w_head[31:0];
            endcase
        end
    end

    assign m_data   = w_word;
    assign m_last   = m_valid & (r_idx == 2'd3);
    assign fill     = r_fill;
    assign overflow = r_overflow;

`ifdef AES_OUT_PARITY_EN
    function automatic logic [15:0] f_byte_par(input logic [127:0] d);
        logic [15:0] p;
        p = '0;
        for (int unsigned b = 0; b < 16; b++) p[b] = ^d[8*b +: 8];
        return p;
    endfunction

    logic [15:0] r_pmem [DEPTH];
    logic        r_par_err;

    always_ff @(posedge clk) begin
        if (w_push) r_pmem[r_wr_ptr] <= f_byte_par(core_out);
    end

    // Stored data is re-checked once, when the whole block leaves the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_par_err <= 1'b0;
        else if (w_pop && (f_byte_par(w_head) != r_pmem[r_rd_ptr]))
            r_par_err <= 1'b1;
    end

    always_comb begin
        m_par = '0;
        for (int unsigned k = 0; k < 4; k++) m_par[k] = ^m_data[8*k +: 8];
    end

    assign par_err = r_par_err;
`endif

endmodule
